// File: rtl/credit_counter_if.sv
// credit_counter_if: take/give/drain/clear bundle of credit_counter; err_o exists only under CREDIT_COUNTER_ERR_EN.
interface credit_counter_if #(parameter int width = 8);
  logic take_valid_i, take_ready_o, give_i, drain_i, clr_i, empty_o, full_o, drained_o;
  logic [width-1:0] count_o;
`ifdef CREDIT_COUNTER_ERR_EN
  logic err_o;
  modport master (output take_valid_i, give_i, drain_i, clr_i,
                  input take_ready_o, count_o, empty_o, full_o, drained_o, err_o);
  modport slave (input take_valid_i, give_i, drain_i, clr_i,
                 output take_ready_o, count_o, empty_o, full_o, drained_o, err_o);
`else
  modport master (output take_valid_i, give_i, drain_i, clr_i,
                  input take_ready_o, count_o, empty_o, full_o, drained_o);
  modport slave (input take_valid_i, give_i, drain_i, clr_i,
                 output take_ready_o, count_o, empty_o, full_o, drained_o);
`endif
endinterface

// File: rtl/credit_counter.sv
// credit_counter: saturating credit pool with take/give, drain and clear; CREDIT_COUNTER_ERR_EN adds a sticky err_o.
module credit_counter #(
  parameter int width = 8,
  parameter int unsigned init_credit = 2**width-1,
  parameter int speed = 0
) (
  input logic clk_i,
  input logic rst_ni,
  credit_counter_if.slave bus
);
  localparam logic [0:0] RUN = 1'b0, DRAIN = 1'b1;
  localparam logic [width-1:0] init_c = width'(init_credit);
  // a[i] = &p[i:0]; speed picks serial, Brent-Kung or Sklansky prefix
  function automatic logic [width-1:0] prefix_and(input logic [width-1:0] p);
    logic [width-1:0] a;
    a = p;
    if (speed == 0) begin
      for (int i = 1; i < width; i++) a[i] = a[i] & a[i-1];
    end else if (speed == 1) begin
      for (int l = 0; (1 << l) < width; l++)
        for (int i = (2 << l) - 1; i < width; i += 2 << l) a[i] = a[i] & a[i-(1 << l)];
      for (int l = $clog2(width) - 1; l >= 0; l--)
        for (int i = 3 * (1 << l) - 1; i < width; i += 2 << l) a[i] = a[i] & a[i-(1 << l)];
    end else begin
      for (int l = 0; (1 << l) < width; l++)
        for (int i = 0; i < width; i++)
          if (((i >> l) & 1) == 1) a[i] = a[i] & a[((i >> l) << l) - 1];
    end
    return a;
  endfunction
  logic [0:0] state_q, state_d;
  logic [width-1:0] count_q, count_d, count_n, carry, pre;
  logic take_ready, take_fire, cin, dec, ovf, drained;
  assign take_ready = state_q == RUN && count_q != '0;
  always_comb begin
    take_fire = bus.take_valid_i && take_ready;
    cin = take_fire ^ bus.give_i;
    dec = take_fire;
    pre = prefix_and(count_q ^ {width{dec}});
    carry = {pre[width-2:0], 1'b1} & {width{cin}};
    ovf = cin && !dec && pre[width-1];
    count_n = ovf ? count_q : count_q ^ carry;
    count_d = bus.clr_i ? init_c : count_n;
    drained = !bus.clr_i && state_q == DRAIN && count_n == init_c;
    state_d = bus.clr_i ? RUN : state_q == RUN ? (bus.drain_i ? DRAIN : RUN) : (drained ? RUN : DRAIN);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      count_q <= init_c;
      state_q <= RUN;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  assign bus.take_ready_o = take_ready;
  assign bus.count_o = count_q;
  assign bus.empty_o = count_q == '0;
  assign bus.full_o = count_q == init_c;
  assign bus.drained_o = drained;
`ifdef CREDIT_COUNTER_ERR_EN
  logic err_q, err_d;
  always_comb err_d = bus.clr_i ? 1'b0 : err_q | (cin && !dec && count_q >= init_c);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) err_q <= 1'b0;
    else err_q <= err_d;
  assign bus.err_o = err_q;
`endif
endmodule

// File: tb/tb_credit_counter.sv
// tb_credit_counter: three credit_counter instances (init 3/15/3, all prefix styles) against a shared arithmetic model.
module tb_credit_counter;
  logic clk = 0, rst_n = 0, take_valid = 0, give = 0, drain = 0, clr = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  credit_counter_if #(.width(4)) bus0 ();
  credit_counter_if #(.width(4)) bus1 ();
  credit_counter_if #(.width(4)) bus2 ();
  assign bus0.take_valid_i = take_valid;
  assign bus0.give_i = give;
  assign bus0.drain_i = drain;
  assign bus0.clr_i = clr;
  assign bus1.take_valid_i = take_valid;
  assign bus1.give_i = give;
  assign bus1.drain_i = drain;
  assign bus1.clr_i = clr;
  assign bus2.take_valid_i = take_valid;
  assign bus2.give_i = give;
  assign bus2.drain_i = drain;
  assign bus2.clr_i = clr;
  credit_counter #(.width(4), .init_credit(3), .speed(0)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));
  credit_counter #(.width(4), .init_credit(15), .speed(1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));
  credit_counter #(.width(4), .init_credit(3), .speed(2)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(bus2));
  logic [3:0] cnt[3];
  logic rdy[3], emp[3], ful[3], drd[3];
  assign cnt = '{bus0.count_o, bus1.count_o, bus2.count_o};
  assign rdy = '{bus0.take_ready_o, bus1.take_ready_o, bus2.take_ready_o};
  assign emp = '{bus0.empty_o, bus1.empty_o, bus2.empty_o};
  assign ful = '{bus0.full_o, bus1.full_o, bus2.full_o};
  assign drd = '{bus0.drained_o, bus1.drained_o, bus2.drained_o};
`ifdef CREDIT_COUNTER_ERR_EN
  logic er[3];
  assign er = '{bus0.err_o, bus1.err_o, bus2.err_o};
`endif
  int m_cnt[3] = '{3, 15, 3};
  bit m_dr[3] = '{0, 0, 0};
  bit m_err[3] = '{0, 0, 0};
  function automatic int init_of(int i);
    return i == 1 ? 15 : 3;
  endfunction
  function automatic bit fire(int i);
    return take_valid && !m_dr[i] && m_cnt[i] != 0;
  endfunction
  function automatic int nxt(int i);
    int n = m_cnt[i] + int'(give) - int'(fire(i));
    return n > 15 ? 15 : n;
  endfunction
  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 3; i++)
      if (!rst_n || clr) begin
        m_cnt[i] <= init_of(i);
        m_dr[i] <= 0;
        m_err[i] <= 0;
      end else begin
        m_cnt[i] <= nxt(i);
        m_dr[i] <= m_dr[i] ? nxt(i) != init_of(i) : drain;
        if (give && !fire(i) && m_cnt[i] >= init_of(i)) m_err[i] <= 1;
      end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("count%0d", i), cnt[i], m_cnt[i]);
      chk($sformatf("ready%0d", i), rdy[i], !m_dr[i] && m_cnt[i] != 0);
      chk($sformatf("empty%0d", i), emp[i], m_cnt[i] == 0);
      chk($sformatf("full%0d", i), ful[i], m_cnt[i] == init_of(i));
      chk($sformatf("drained%0d", i), drd[i], rst_n && !clr && m_dr[i] && nxt(i) == init_of(i));
`ifdef CREDIT_COUNTER_ERR_EN
      chk($sformatf("err%0d", i), er[i], m_err[i]);
`endif
    end
  task automatic step(input logic tv, g, d, c);
    @(posedge clk);
    #1;
    take_valid = tv;
    give = g;
    drain = d;
    clr = c;
    @(negedge clk);
  endtask
  int e032[5] = '{3, 2, 1, 0, 0};
  initial begin
    @(negedge clk);
    chk("rst_count0", cnt[0], 3);
    chk("rst_count1", cnt[1], 15);
    chk("rst_ready0", rdy[0], 1);
    chk("rst_full0", ful[0], 1);
    chk("rst_empty0", emp[0], 0);
    @(posedge clk);
    #1 rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 0);
      chk("take_count0", cnt[0], e032[k]);
      chk("take_ready0", rdy[0], k < 3);
      chk("take_empty0", emp[0], k >= 3);
      chk("take_count1", cnt[1], 15 - k);
    end
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("both_pre0", cnt[0], 2);
    step(0, 0, 0, 0);
    chk("both_post0", cnt[0], 2);
    chk("both_post1", cnt[1], 12);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("drain_req_count0", cnt[0], 1);
    chk("drain_req_ready0", rdy[0], 1);
    step(0, 0, 0, 0);
    chk("drain_ready0_a", rdy[0], 0);
    step(0, 1, 0, 0);
    chk("drain_give1_ready0", rdy[0], 0);
    chk("drain_give1_drained0", drd[0], 0);
    step(1, 0, 1, 0);
    chk("drain_ready0_b", rdy[0], 0);
    chk("drain_count0_b", cnt[0], 2);
    step(0, 1, 0, 0);
    chk("drain_give2_drained0", drd[0], 1);
    chk("drain_give2_ready0", rdy[0], 0);
    step(0, 0, 0, 0);
    chk("drain_done_count0", cnt[0], 3);
    chk("drain_done_ready0", rdy[0], 1);
    chk("drain_done_drained0", drd[0], 0);
    chk("drain_count1", cnt[1], 13);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("drain_done_drained1", drd[1], 1);
    step(0, 1, 0, 0);
    chk("ovf_pre1", cnt[1], 15);
    step(0, 0, 0, 0);
    chk("ovf_count1", cnt[1], 15);
    chk("over_init_count0", cnt[0], 6);
    chk("over_init_full0", ful[0], 0);
`ifdef CREDIT_COUNTER_ERR_EN
    chk("ovf_err1", er[1], 1);
    chk("over_init_err0", er[0], 1);
`endif
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("clr_drain_count0", cnt[0], 0);
    step(0, 1, 0, 1);
    chk("clr_give_drained0", drd[0], 0);
    chk("clr_give_ready0", rdy[0], 0);
    step(1, 0, 0, 1);
    chk("clr_count0", cnt[0], 3);
    chk("clr_ready0", rdy[0], 1);
    chk("clr_count1", cnt[1], 15);
    step(0, 0, 0, 0);
    chk("clr_take_discard0", cnt[0], 3);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("drain_at_full_drained0", drd[0], 1);
    chk("drain_at_full_ready0", rdy[0], 0);
    step(0, 0, 0, 0);
    chk("drain_at_full_after0", drd[0], 0);
    chk("drain_at_full_ready0b", rdy[0], 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("mid_drain_count0", cnt[0], 1);
    chk("mid_drain_ready0", rdy[0], 0);
    #2 rst_n = 0;
    #1;
    chk("async_count0", cnt[0], 3);
    chk("async_ready0", rdy[0], 1);
    chk("async_full0", ful[0], 1);
    chk("async_empty0", emp[0], 0);
    chk("async_drained0", drd[0], 0);
    chk("async_count1", cnt[1], 15);
    @(posedge clk);
    #1 rst_n = 1;
    step(0, 0, 0, 0);
    chk("post_rst_ready0", rdy[0], 1);
    for (int k = 0; k < 80; k++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
    step(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/credit_counter.md
CREDIT_COUNTER -- requirements
Module: credit_counter

Interface
REQ-001 Parameter width, default 8: credit count word width, at least 2.
REQ-002 Parameter init_credit, default 2**width-1: credit count after reset and after clear, at most 2**width-1.
REQ-003 Parameter speed, default 0: prefix structure of the inc/dec datapath (0 serial, 1 Brent-Kung, 2 Sklansky); no functional effect.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 take_valid_i  in  1  consumer requests one credit.
REQ-007 take_ready_o  out  1  a credit is available for take.
REQ-008 give_i  in  1  one credit returned this cycle; no handshake.
REQ-009 drain_i  in  1  single-cycle pulse that starts a drain.
REQ-010 clr_i  in  1  synchronous clear; reloads init_credit.
REQ-011 count_o  out  width  current credit count, driven from a register.
REQ-012 empty_o  out  1  count_o == 0.
REQ-013 full_o  out  1  count_o == init_credit.
REQ-014 drained_o  out  1  single-cycle pulse when a drain completes.
REQ-015 err_o  out  1  sticky error flag; present only under CREDIT_COUNTER_ERR_EN.

Function
REQ-016 Take fires when take_valid_i && take_ready_o.
REQ-017 Next count is computed by a single incrementer-decrementer with carry-in = take_fire XOR give_i and DEC = take_fire.
- take only: count-1.
- give only: count+1.
- both or neither: unchanged.
REQ-018 count_o reflects a take or give on the next clock edge (latency 1).
REQ-019 take_ready_o = (state==RUN) && (count_o != 0); it has no combinational dependency on give_i or take_valid_i.
REQ-020 Overflow: give_i while count_o == 2**width-1 with no take fire leaves the count unchanged (saturates, no wrap).
REQ-021 Underflow is impossible through take, because of the ready gating in REQ-019.
REQ-022 FSM states RUN and DRAIN; reset state is RUN.
REQ-023 RUN -> DRAIN when drain_i is asserted.
REQ-024 In DRAIN, take_ready_o = 0 and give_i is still counted.
REQ-025 DRAIN -> RUN on the first edge where the next count == init_credit.
- drained_o pulses high during that cycle.
- drain_i asserted with count_o == init_credit and no give_i: one cycle in DRAIN, then drained_o.
REQ-026 drain_i received while in DRAIN is ignored.
REQ-027 clr_i has priority over take, give and drain_i.
- Next count = init_credit, next state = RUN.
- take_ready_o is not forced low in the clr_i cycle; a take that fires in that cycle is discarded.
- drained_o stays low.

Reset
REQ-028 While rst_ni = 0, asynchronously:
- count_o = init_credit, state = RUN, take_ready_o = (init_credit != 0).
- empty_o = (init_credit == 0), full_o = 1, drained_o = 0, err_o = 0.
REQ-029 Reset asserted mid-drain abandons the drain without a drained_o pulse.

Configuration
REQ-030 Macro CREDIT_COUNTER_ERR_EN defined: err_o exists and is set on either event below; only reset or clr_i clears it.
- a REQ-020 overflow;
- give_i causing count > init_credit.
REQ-031 Macro CREDIT_COUNTER_ERR_EN undefined: no err_o port and no error logic; counting behaviour is identical.

Verification
REQ-032 width=4, init_credit=3: take_valid_i held high for 5 cycles -> count_o 3,2,1,0; take_ready_o=0 and empty_o=1 from cycle 3.
REQ-033 count_o=2, take fire and give_i in the same cycle -> count_o stays 2 on the next edge.
REQ-034 width=4, init_credit=15, give_i at count 15 -> count_o stays 15; err_o=1 next cycle with the macro defined.
REQ-035 init_credit=3, count 1, drain_i, then give_i on two later cycles -> take_ready_o=0 throughout; drained_o pulses in the cycle of the second give; RUN resumes with count 3.
REQ-036 count 0 in DRAIN, clr_i together with give_i -> count_o = init_credit, state RUN, no drained_o.
REQ-037 rst_ni low asynchronously mid-drain at count 1 -> outputs take their REQ-028 values without waiting for a clock edge.
